writeback_stage: RTL

- Final pipeline stage. Consumes the per-instruction result produced by the memory stage: valid, inst, inst_pc, value, reg-write enable, difftest_skip.
- Owns the 32-entry architectural integer register file.
- Serves the two decode-stage read ports, with same-cycle write bypass.
- Emits a registered one-cycle commit record for difftest, keeps a retired-instruction counter, and stops the pipeline on the simulator halt instruction.

---
 rtl/writeback_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: owns the architectural integer register file, retires one
// instruction per cycle, emits a registered difftest commit record and halts on HALT_INST.
module writeback_stage #(
   parameter int          XLEN      = 64,
   parameter logic [31:0] HALT_INST = 32'h0000006b
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_value,
   input  logic            in_wen,
   input  logic            in_skip,
   input  logic [4:0]      rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs2_data,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [31:0]     commit_inst,
   output logic            commit_wen,
   output logic [4:0]      commit_wdest,
   output logic [XLEN-1:0] commit_wdata,
   output logic            commit_skip,
   output logic [63:0]     retired,
   output logic            halted,
   output logic [XLEN-1:0] halt_code
);

   // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
   // in_valid without in_ready has no effect; upstream holds its request.
   // in_ready depends only on state, never on in_valid.

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [XLEN-1:0] regfile [32];

   logic       accept;
   logic [4:0] rd;
   logic       rd_write;
   logic       is_halt;

   assign rd       = in_inst[11:7];
   assign accept   = in_valid && in_ready;
   assign rd_write = accept && in_wen && (rd != 5'd0);
   assign is_halt  = (in_inst == HALT_INST);

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and state-derived outputs; halted doubles as the state view
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      halted   = 1'b0;
      case (state_q)
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && is_halt) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Register file; x0 is never written so it always holds zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regfile[i] <= '0;
         end
      end else if (rd_write) begin
         regfile[rd] <= in_value;
      end
   end

   // Read ports with same-cycle write bypass
   always_comb begin
      rs1_data = regfile[rs1_addr];
      if (rs1_addr == 5'd0) begin
         rs1_data = '0;
      end else if (rd_write && (rd == rs1_addr)) begin
         rs1_data = in_value;
      end
   end

   always_comb begin
      rs2_data = regfile[rs2_addr];
      if (rs2_addr == 5'd0) begin
         rs2_data = '0;
      end else if (rd_write && (rd == rs2_addr)) begin
         rs2_data = in_value;
      end
   end

   // Commit record: payload fields hold their last value between pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_valid <= 1'b0;
         commit_pc    <= '0;
         commit_inst  <= '0;
         commit_wen   <= 1'b0;
         commit_wdest <= '0;
         commit_wdata <= '0;
         commit_skip  <= 1'b0;
      end else begin
         commit_valid <= accept;
         if (accept) begin
            commit_pc    <= in_pc;
            commit_inst  <= in_inst;
            commit_wen   <= in_wen && (rd != 5'd0);
            commit_wdest <= rd;
            commit_wdata <= in_value;
            commit_skip  <= in_skip;
         end
      end
   end

   // Retired counter wraps naturally at 2^64
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired <= '0;
      end else if (accept) begin
         retired <= retired + 64'd1;
      end
   end

   // Exit code sees x10 as written by the halt instruction itself, if it does
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_code <= '0;
      end else if (accept && is_halt) begin
         halt_code <= (rd_write && (rd == 5'd10)) ? in_value : regfile[10];
      end
   end

endmodule
